// File: rtl/cpu_pkg.sv
// Shared types and instruction field positions for the 8-bit CPU sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_LDI  = 3'd3,
    OP_IN   = 3'd4,
    OP_OUT  = 3'd5,
    OP_JZ   = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_WAIT_IN = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WR_ALU = 2'd0,
    WR_IMM = 2'd1,
    WR_SW  = 2'd2
  } wr_sel_e;

  localparam int unsigned OPC_MSB = 11;
  localparam int unsigned OPC_LSB = 9;
  localparam int unsigned RD_MSB  = 8;
  localparam int unsigned RD_LSB  = 6;
  localparam int unsigned RA_MSB  = 5;
  localparam int unsigned RA_LSB  = 3;
  localparam int unsigned RB_MSB  = 2;
  localparam int unsigned RB_LSB  = 0;

  typedef struct packed {
    logic    rf_we;
    wr_sel_e wr_sel;
    logic    alu_op;
    logic    out_we;
    logic    is_in;
    logic    is_jz;
    logic    is_halt;
  } ctrl_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath signal bundle; master is the sequencer, slave the datapath.
interface cpu_sequencer_if #(
  parameter int unsigned INSTR_WIDTH      = 12,
  parameter int unsigned INSTR_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH   = 3,
  parameter int unsigned BUS_WIDTH        = 8
);
  logic [INSTR_WIDTH-1:0]      instr;
  logic [BUS_WIDTH-1:0]        alu_result;
  logic                        ready_in;
  logic                        in_ack;
  logic                        pc_en;
  logic                        pc_load;
  logic [INSTR_ADDR_WIDTH-1:0] pc_target;
  logic                        rf_we;
  logic [REG_ADDR_WIDTH-1:0]   rf_wr_addr;
  logic [REG_ADDR_WIDTH-1:0]   rf_rd_addr_a;
  logic [REG_ADDR_WIDTH-1:0]   rf_rd_addr_b;
  logic                        alu_op;
  logic [1:0]                  wr_sel;
  logic [BUS_WIDTH-1:0]        wr_imm;
  logic                        out_we;
  logic                        zero;
  logic                        halted;

  modport master (
    input  instr, alu_result, ready_in,
    output in_ack, pc_en, pc_load, pc_target, rf_we, rf_wr_addr, rf_rd_addr_a,
           rf_rd_addr_b, alu_op, wr_sel, wr_imm, out_we, zero, halted
  );

  modport slave (
    output instr, alu_result, ready_in,
    input  in_ack, pc_en, pc_load, pc_target, rf_we, rf_wr_addr, rf_rd_addr_a,
           rf_rd_addr_b, alu_op, wr_sel, wr_imm, out_we, zero, halted
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational opcode -> control bundle for the EXEC cycle.
module instr_decoder
  import cpu_pkg::*;
(
  input  opcode_e opcode_i,
  output ctrl_t   ctrl_o
);
  always_comb begin
    ctrl_o.rf_we   = 1'b0;
    ctrl_o.wr_sel  = WR_ALU;
    ctrl_o.alu_op  = 1'b0;
    ctrl_o.out_we  = 1'b0;
    ctrl_o.is_in   = 1'b0;
    ctrl_o.is_jz   = 1'b0;
    ctrl_o.is_halt = 1'b0;
    unique case (opcode_i)
      OP_NOP:  ;
      OP_ADD:  ctrl_o.rf_we = 1'b1;
      OP_SUB: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.alu_op = 1'b1;
      end
      OP_LDI: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.wr_sel = WR_IMM;
      end
      // IN's write depends on ready_in, so the FSM issues it, not the decoder
      OP_IN: begin
        ctrl_o.is_in  = 1'b1;
        ctrl_o.wr_sel = WR_SW;
      end
      OP_OUT:  ctrl_o.out_we  = 1'b1;
      OP_JZ:   ctrl_o.is_jz   = 1'b1;
      OP_HALT: ctrl_o.is_halt = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: latches the instruction, decodes it, drives PC/RF/ALU controls.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH      = 12,
  parameter int unsigned OPCODE_WIDTH     = 3,
  parameter int unsigned INSTR_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH   = 3,
  parameter int unsigned BUS_WIDTH        = 8
) (
  input logic             clk,
  input logic             n_reset,
  cpu_sequencer_if.master bus
);
  state_e                      state_q, state_d;
  logic [INSTR_WIDTH-1:0]      ir_q;
  logic                        zero_q, zero_d;
  logic [OPCODE_WIDTH-1:0]     opc_bits;
  ctrl_t                       ctrl;

  logic                        in_ack, pc_en, pc_load, rf_we, alu_op, out_we, halted;
  logic [INSTR_ADDR_WIDTH-1:0] pc_tgt;
  wr_sel_e                     wr_sel;

  assign opc_bits = ir_q[OPC_MSB:OPC_LSB];

  instr_decoder u_dec (
    .opcode_i (opcode_e'(opc_bits)),
    .ctrl_o   (ctrl)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      if (state_q == S_FETCH) ir_q <= bus.instr;
    end
  end

  // Outputs are gated by n_reset so a reset landing mid-EXEC issues no write
  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    in_ack  = 1'b0;
    pc_en   = 1'b0;
    pc_load = 1'b0;
    pc_tgt  = '0;
    rf_we   = 1'b0;
    alu_op  = 1'b0;
    wr_sel  = WR_ALU;
    out_we  = 1'b0;
    halted  = 1'b0;
    if (n_reset) begin
      unique case (state_q)
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          state_d = S_FETCH;
          if (ctrl.is_halt) begin
            state_d = S_HALT;
          end else if (ctrl.is_in) begin
            if (bus.ready_in) begin
              rf_we  = 1'b1;
              wr_sel = WR_SW;
              in_ack = 1'b1;
              pc_en  = 1'b1;
            end else begin
              state_d = S_WAIT_IN;
            end
          end else if (ctrl.is_jz) begin
            if (zero_q) begin
              pc_load = 1'b1;
              pc_tgt  = ir_q[INSTR_ADDR_WIDTH-1:0];
            end else begin
              pc_en = 1'b1;
            end
          end else begin
            rf_we  = ctrl.rf_we;
            wr_sel = ctrl.wr_sel;
            alu_op = ctrl.alu_op;
            out_we = ctrl.out_we;
            pc_en  = 1'b1;
            if (ctrl.rf_we && ctrl.wr_sel == WR_ALU) zero_d = (bus.alu_result == '0);
          end
        end
        S_WAIT_IN: begin
          if (bus.ready_in) begin
            rf_we   = 1'b1;
            wr_sel  = WR_SW;
            in_ack  = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_HALT:  halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.in_ack       = in_ack;
  assign bus.pc_en        = pc_en;
  assign bus.pc_load      = pc_load;
  assign bus.pc_target    = pc_tgt;
  assign bus.rf_we        = rf_we;
  assign bus.alu_op       = alu_op;
  assign bus.wr_sel       = wr_sel;
  assign bus.out_we       = out_we;
  assign bus.halted       = halted;
  assign bus.zero         = zero_q;
  assign bus.rf_wr_addr   = ir_q[RD_MSB:RD_LSB];
  assign bus.rf_rd_addr_a = ir_q[RA_MSB:RA_LSB];
  assign bus.rf_rd_addr_b = ir_q[RB_MSB:RB_LSB];
  assign bus.wr_imm       = BUS_WIDTH'(ir_q[RA_MSB:RB_LSB]);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with hand-computed per-cycle expectations.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic n_reset;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .INSTR_WIDTH      (12),
    .OPCODE_WIDTH     (3),
    .INSTR_ADDR_WIDTH (4),
    .REG_ADDR_WIDTH   (3),
    .BUS_WIDTH        (8)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [11:0] enc(input int unsigned op, input int unsigned rd,
                                      input int unsigned ra, input int unsigned rb);
    logic [2:0] o, d, a, b;
    o = 3'(op); d = 3'(rd); a = 3'(ra); b = 3'(rb);
    return {o, d, a, b};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset        = 1'b0;
    bus.instr      = '0;
    bus.alu_result = '0;
    bus.ready_in   = 1'b0;
    step(); step();
    #1;
    check_eq("rst_pc_en", 32'(bus.pc_en), 0);
    check_eq("rst_rf_we", 32'(bus.rf_we), 0);
    check_eq("rst_zero", 32'(bus.zero), 0);
    check_eq("rst_halted", 32'(bus.halted), 0);

    // Reset held 2 cycles mid-EXEC of ADD r1,r2,r3 (alu_result 0)
    n_reset   = 1'b1;
    bus.instr = enc(1, 1, 2, 3);
    step();                                   // FETCH -> EXEC
    n_reset = 1'b0;
    #1;
    check_eq("rstexec_rf_we", 32'(bus.rf_we), 0);
    check_eq("rstexec_pc_en", 32'(bus.pc_en), 0);
    step();
    #1;
    check_eq("rstexec2_rf_we", 32'(bus.rf_we), 0);
    step();
    n_reset = 1'b1;
    #1;
    check_eq("rel_zero", 32'(bus.zero), 0);
    check_eq("rel_halted", 32'(bus.halted), 0);
    check_eq("rel_rf_we", 32'(bus.rf_we), 0);

    // LDI r1,5 ; LDI r2,5 ; SUB r3,r1,r2
    bus.instr = enc(3, 1, 0, 5);
    step();
    #1;
    check_eq("ldi1_rf_we", 32'(bus.rf_we), 1);
    check_eq("ldi1_wr_sel", 32'(bus.wr_sel), 1);
    check_eq("ldi1_wr_addr", 32'(bus.rf_wr_addr), 1);
    check_eq("ldi1_wr_imm", 32'(bus.wr_imm), 5);
    check_eq("ldi1_pc_en", 32'(bus.pc_en), 1);
    step();
    bus.instr = enc(3, 2, 0, 5);
    #1;
    check_eq("fetch_rf_we", 32'(bus.rf_we), 0);
    check_eq("fetch_pc_en", 32'(bus.pc_en), 0);
    step();
    #1;
    check_eq("ldi2_rf_we", 32'(bus.rf_we), 1);
    check_eq("ldi2_wr_addr", 32'(bus.rf_wr_addr), 2);
    step();
    bus.instr = enc(2, 3, 1, 2);
    bus.alu_result = 8'd0;
    step();
    #1;
    check_eq("sub_rf_we", 32'(bus.rf_we), 1);
    check_eq("sub_wr_addr", 32'(bus.rf_wr_addr), 3);
    check_eq("sub_alu_op", 32'(bus.alu_op), 1);
    check_eq("sub_wr_sel", 32'(bus.wr_sel), 0);
    check_eq("sub_rd_a", 32'(bus.rf_rd_addr_a), 1);
    check_eq("sub_rd_b", 32'(bus.rf_rd_addr_b), 2);
    check_eq("sub_zero_pre", 32'(bus.zero), 0);
    step();
    #1;
    check_eq("sub_zero_post", 32'(bus.zero), 1);

    // JZ 4 with zero = 1
    bus.instr = {3'd6, 5'd0, 4'd4};
    step();
    #1;
    check_eq("jz1_pc_load", 32'(bus.pc_load), 1);
    check_eq("jz1_target", 32'(bus.pc_target), 4);
    check_eq("jz1_pc_en", 32'(bus.pc_en), 0);
    step();

    // ADD r5,r1,r2 with alu_result 7 clears zero; then JZ not taken
    bus.instr = enc(1, 5, 1, 2);
    bus.alu_result = 8'd7;
    step();
    #1;
    check_eq("add_alu_op", 32'(bus.alu_op), 0);
    check_eq("add_rf_we", 32'(bus.rf_we), 1);
    step();
    #1;
    check_eq("add_zero_post", 32'(bus.zero), 0);
    bus.instr = {3'd6, 5'd0, 4'd9};
    step();
    #1;
    check_eq("jz0_pc_en", 32'(bus.pc_en), 1);
    check_eq("jz0_pc_load", 32'(bus.pc_load), 0);
    check_eq("jz0_target", 32'(bus.pc_target), 0);
    step();

    // IN r4: EXEC with ready low, 5 WAIT_IN cycles low, then ready
    bus.instr = enc(4, 4, 0, 0);
    bus.ready_in = 1'b0;
    step();
    #1;
    check_eq("in_exec_ack", 32'(bus.in_ack), 0);
    check_eq("in_exec_pc_en", 32'(bus.pc_en), 0);
    check_eq("in_exec_rf_we", 32'(bus.rf_we), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check_eq("wait_ack", 32'(bus.in_ack), 0);
      check_eq("wait_rf_we", 32'(bus.rf_we), 0);
      check_eq("wait_pc_en", 32'(bus.pc_en), 0);
    end
    step();
    bus.ready_in = 1'b1;
    #1;
    check_eq("in_rf_we", 32'(bus.rf_we), 1);
    check_eq("in_wr_sel", 32'(bus.wr_sel), 2);
    check_eq("in_wr_addr", 32'(bus.rf_wr_addr), 4);
    check_eq("in_ack", 32'(bus.in_ack), 1);
    check_eq("in_pc_en", 32'(bus.pc_en), 1);
    step();
    bus.instr = enc(4, 6, 0, 0);
    #1;
    check_eq("in_fetch_ack", 32'(bus.in_ack), 0);
    step();
    #1;
    check_eq("in2_ack", 32'(bus.in_ack), 1);
    check_eq("in2_wr_addr", 32'(bus.rf_wr_addr), 6);
    check_eq("in2_pc_en", 32'(bus.pc_en), 1);
    step();
    bus.ready_in = 1'b0;

    // OUT r3
    bus.instr = enc(5, 0, 3, 0);
    step();
    #1;
    check_eq("out_we", 32'(bus.out_we), 1);
    check_eq("out_rd_a", 32'(bus.rf_rd_addr_a), 3);
    check_eq("out_pc_en", 32'(bus.pc_en), 1);
    check_eq("out_rf_we", 32'(bus.rf_we), 0);
    step();
    #1;
    check_eq("out_we_off", 32'(bus.out_we), 0);

    // HALT, then reset out of it
    bus.instr = enc(7, 0, 0, 0);
    step();
    #1;
    check_eq("halt_exec_pc_en", 32'(bus.pc_en), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      check_eq("halt_halted", 32'(bus.halted), 1);
      check_eq("halt_pc_en", 32'(bus.pc_en), 0);
    end
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    bus.instr = enc(0, 0, 0, 0);
    #1;
    check_eq("unhalt_halted", 32'(bus.halted), 0);
    check_eq("unhalt_fetch_pc_en", 32'(bus.pc_en), 0);
    step();
    #1;
    check_eq("nop_pc_en", 32'(bus.pc_en), 1);
    check_eq("nop_rf_we", 32'(bus.rf_we), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
